irq_pending_latch: RTL and testbench

Sixteen-channel interrupt request front end that drives the 16-bit request vector and enable of the priority encoder stage. It detects rising edges on raw request lines, holds each event as a pending bit until software acknowledges it, applies a programmable mask, and flags lost events per channel. Bit 15 is the highest-priority channel as seen by the encoder.

---
 rtl/irq_pending_latch_if.sv | 25 ++
 rtl/irq_pending_latch.sv | 69 ++++++
 tb/tb_irq_pending_latch.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/irq_pending_latch_if.sv
// Request/mask/acknowledge bus between software-facing logic and the IRQ pending latch.
// Parameterless: channel count is fixed at 16 to match the priority encoder input width.
interface irq_pending_latch_if;
  logic [15:0] req;
  logic        mask_wr;
  logic [15:0] mask_in;
  logic        ack;
  logic [3:0]  ack_idx;
  logic        ack_all;
  logic        ovf_clr;
  logic [15:0] p;
  logic        En;
  logic [15:0] ovf;
  logic [15:0] mask;

  modport master (
    output req, mask_wr, mask_in, ack, ack_idx, ack_all, ovf_clr,
    input  p, En, ovf, mask
  );

  modport slave (
    input  req, mask_wr, mask_in, ack, ack_idx, ack_all, ovf_clr,
    output p, En, ovf, mask
  );
endinterface

// File: rtl/irq_pending_latch.sv
// Sixteen-channel interrupt front end: rising-edge detect, pending latch, mask, sticky overflow.
// Define IRQ_PENDING_SYNC_EN to insert a 2-flop synchronizer on req ahead of edge detection.
module irq_pending_latch (
  input  logic              clk,
  input  logic              rst,
  irq_pending_latch_if.slave bus
);
  localparam int unsigned N = 16;

  logic [N-1:0] req_s;
  logic [N-1:0] req_d;
  logic [N-1:0] pending;
  logic [N-1:0] mask_q;
  logic [N-1:0] ovf_q;
  logic [N-1:0] rise;
  logic [N-1:0] clr;
  logic [N-1:0] ovf_set;

`ifdef IRQ_PENDING_SYNC_EN
  logic [N-1:0] sync1;
  logic [N-1:0] sync2;

  // Resets high so lines already asserted at release look like steady levels.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= bus.req;
      sync2 <= sync1;
    end
  end

  assign req_s = sync2;
`else
  assign req_s = bus.req;
`endif

  assign rise = req_s & ~req_d;

  always_comb begin
    clr = '0;
    if (bus.ack) clr[bus.ack_idx] = 1'b1;
    if (bus.ack_all) clr = '1;
  end

  // A new event on a still-pending, uncleared channel is lost.
  assign ovf_set = rise & pending & ~clr;

  always_ff @(posedge clk) begin
    if (rst) begin
      req_d   <= '1;
      pending <= '0;
      mask_q  <= '1;
      ovf_q   <= '0;
    end else begin
      req_d   <= req_s;
      pending <= (pending & ~clr) | rise;
      if (bus.mask_wr) mask_q <= bus.mask_in;
      ovf_q   <= (bus.ovf_clr ? '0 : ovf_q) | ovf_set;
    end
  end

  // p/En stay combinational from registers so mask and ack take effect the same cycle.
  assign bus.p    = pending & ~mask_q;
  assign bus.En   = |bus.p;
  assign bus.ovf  = ovf_q;
  assign bus.mask = mask_q;
endmodule

// File: tb/tb_irq_pending_latch.sv
// Directed bench for irq_pending_latch; follows IRQ_PENDING_SYNC_EN for event latency.
module tb_irq_pending_latch;
`ifdef IRQ_PENDING_SYNC_EN
  localparam int SYNC = 2;
`else
  localparam int SYNC = 0;
`endif

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  irq_pending_latch_if bus ();

  irq_pending_latch dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [15:0] v);
    bus.req = v;
    tick(SYNC + 1);
  endtask

  task automatic do_ack(input logic [3:0] idx);
    bus.ack     = 1'b1;
    bus.ack_idx = idx;
    tick(1);
    bus.ack     = 1'b0;
  endtask

  task automatic write_mask(input logic [15:0] v);
    bus.mask_wr = 1'b1;
    bus.mask_in = v;
    tick(1);
    bus.mask_wr = 1'b0;
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    rst         = 1'b1;
    bus.req     = 16'h0001;
    bus.mask_wr = 1'b0;
    bus.mask_in = 16'h0000;
    bus.ack     = 1'b0;
    bus.ack_idx = 4'd0;
    bus.ack_all = 1'b0;
    bus.ovf_clr = 1'b0;
    tick(3);
    check("rst_p", bus.p, 16'h0000);
    check("rst_en", 16'(bus.En), 16'h0000);
    check("rst_ovf", bus.ovf, 16'h0000);
    check("rst_mask", bus.mask, 16'hFFFF);

    // Held-high line at release is not an event.
    rst = 1'b0;
    write_mask(16'h0000);
    tick(SYNC + 2);
    check("held_p", bus.p, 16'h0000);
    check("held_en", 16'(bus.En), 16'h0000);

    set_req(16'h0000);
    bus.req = 16'h0001;
    tick(SYNC);
    check("lat_before", bus.p, 16'h0000);
    tick(1);
    check("lat_p", bus.p, 16'h0001);
    check("lat_en", 16'(bus.En), 16'h0001);
    do_ack(4'd0);
    check("ack0_p", bus.p, 16'h0000);
    check("ack0_en", 16'(bus.En), 16'h0000);

    // Masked channel still latches; unmask exposes it.
    write_mask(16'h8000);
    check("mask_rb", bus.mask, 16'h8000);
    set_req(16'h8009);
    check("masked_p", bus.p, 16'h0008);
    write_mask(16'h0000);
    check("unmask_p", bus.p, 16'h8008);

    // Ack coinciding with a new rise: set wins, no overflow.
    set_req(16'h0009);
    bus.req = 16'h8009;
    tick(SYNC);
    do_ack(4'd15);
    check("ackrise_p", bus.p, 16'h8008);
    check("ackrise_ovf", bus.ovf, 16'h0000);
    do_ack(4'd3);
    do_ack(4'd15);
    check("clean_p", bus.p, 16'h0000);

    // Two rises on ch7 without ack.
    set_req(16'h8089);
    set_req(16'h8009);
    set_req(16'h8089);
    check("ovf7", bus.ovf, 16'h0080);
    check("ovf7_p", bus.p, 16'h0080);
    bus.ovf_clr = 1'b1;
    tick(1);
    bus.ovf_clr = 1'b0;
    check("ovfclr", bus.ovf, 16'h0000);
    check("ovfclr_p", bus.p, 16'h0080);

    // ovf_clr in the same cycle as a new overflow: overflow wins.
    set_req(16'h8009);
    bus.req = 16'h8089;
    tick(SYNC);
    bus.ovf_clr = 1'b1;
    tick(1);
    bus.ovf_clr = 1'b0;
    check("ovf_vs_clr", bus.ovf, 16'h0080);
    do_ack(4'd7);
    check("ack7_p", bus.p, 16'h0000);
    bus.ovf_clr = 1'b1;
    tick(1);
    bus.ovf_clr = 1'b0;

    // ack_all
    set_req(16'h0000);
    set_req(16'h8101);
    check("multi_p", bus.p, 16'h8101);
    check("multi_en", 16'(bus.En), 16'h0001);
    bus.ack_all = 1'b1;
    tick(1);
    bus.ack_all = 1'b0;
    check("ackall_p", bus.p, 16'h0000);
    check("ackall_en", 16'(bus.En), 16'h0000);

    // Mid-operation reset with pending and overflow set.
    set_req(16'h0000);
    set_req(16'h8101);
    set_req(16'h0000);
    set_req(16'h8101);
    check("pre_rst_p", bus.p, 16'h8101);
    check("pre_rst_ovf", bus.ovf, 16'h8101);
    rst = 1'b1;
    tick(1);
    check("mrst_p", bus.p, 16'h0000);
    check("mrst_en", 16'(bus.En), 16'h0000);
    check("mrst_ovf", bus.ovf, 16'h0000);
    check("mrst_mask", bus.mask, 16'hFFFF);
    rst = 1'b0;
    tick(SYNC + 2);
    write_mask(16'h0000);
    check("post_rst_p", bus.p, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
